// File: rtl/uart_rx_ctrl_if.sv
// Frame-word handoff between the RX frame FSM, the receive controller and the host consumer.
// The master side is the controller: it takes completed frames in and presents the FIFO head out.
interface uart_rx_ctrl_if;
    logic        RX_DATA_EN;
    logic [9:0]  RX_DATA_T;
    logic [7:0]  DATA;
    logic        PERR;
    logic        FERR;
    logic        VALID;
    logic        READY;

    modport master (
        input  RX_DATA_EN, RX_DATA_T, READY,
        output DATA, PERR, FERR, VALID
    );

    modport slave (
        output RX_DATA_EN, RX_DATA_T, READY,
        input  DATA, PERR, FERR, VALID
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: mid-bit sampling strobe, 4-deep frame FIFO with valid/ready head,
// sticky overflow flag and saturating error-frame counter.
module uart_rx_ctrl #(
    parameter int DIV = 434
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            i_RXCT_R,
    output logic            o_RX_CE,
    output logic [2:0]      o_LEVEL,
    output logic            o_OVF,
    output logic [7:0]      o_ERR_CNT,
    input  logic            i_CLR,
    uart_rx_ctrl_if.master  bus
);
    localparam int              CW    = $clog2(DIV + 1);
    localparam logic [CW-1:0]   HALF  = CW'(DIV / 2);
    localparam logic [CW-1:0]   FULLP = CW'(DIV);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [CW-1:0] r_cnt;
    logic          r_rx_ce;
    logic [9:0]    r_mem [4];
    logic [1:0]    r_wptr;
    logic [1:0]    r_rptr;
    logic [2:0]    r_count;
    logic          r_ovf;
    logic [7:0]    r_err_cnt;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_err_frame;
    logic [9:0]    w_head;

    assign w_full      = (r_count == 3'd4);
    assign w_pop       = (r_count != 3'd0) && bus.READY;
    assign w_push      = bus.RX_DATA_EN && (!w_full || w_pop);
    assign w_err_frame = bus.RX_DATA_EN && (bus.RX_DATA_T[9] | bus.RX_DATA_T[8]);
    assign w_head      = r_mem[r_rptr];

    // Bit timer: loading HALF while held puts the first strobe in the middle of the start bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt   <= HALF;
            r_rx_ce <= 1'b0;
        end else if (i_RXCT_R) begin
            r_cnt   <= HALF;
            r_rx_ce <= 1'b0;
        end else if (r_cnt == CW'(1)) begin
            r_cnt   <= FULLP;
            r_rx_ce <= 1'b1;
        end else begin
            r_cnt   <= r_cnt - CW'(1);
            r_rx_ce <= 1'b0;
        end
    end

    // Frame FIFO: a full FIFO still accepts a push when the head leaves in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= '0;
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= bus.RX_DATA_T;
                r_wptr        <= r_wptr + 2'd1;
            end
            if (w_pop) r_rptr <= r_rptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Status: clear wins over a same-cycle overflow or error event.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else if (i_CLR) begin
            r_ovf     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            if (bus.RX_DATA_EN && w_full && !w_pop) r_ovf <= 1'b1;
            if (w_err_frame) r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    assign o_RX_CE   = r_rx_ce;
    assign o_LEVEL   = r_count;
    assign o_OVF     = r_ovf;
    assign o_ERR_CNT = r_err_cnt;
    assign bus.VALID = (r_count != 3'd0);
    assign bus.DATA  = w_head[7:0];
    assign bus.PERR  = w_head[8];
    assign bus.FERR  = w_head[9];
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: vector table, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_uart_rx_ctrl;
    localparam int DIV  = 8;
    localparam int HALF = DIV / 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       rxct = 1'b1;
    logic       clr = 1'b0;
    logic       rx_ce;
    logic [2:0] level;
    logic       ovf;
    logic [7:0] errcnt;

    uart_rx_ctrl_if bus();

    uart_rx_ctrl #(.DIV(DIV)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .i_RXCT_R  (rxct),
        .o_RX_CE   (rx_ce),
        .o_LEVEL   (level),
        .o_OVF     (ovf),
        .o_ERR_CNT (errcnt),
        .i_CLR     (clr),
        .bus       (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: frame queue, flags, and the length of the current RXCT_R=0 run.
    logic [9:0] mq[$];
    int         m_err;
    bit         m_ovf;
    int         m_run;
    bit         m_ce;

    typedef struct {
        bit         en;
        logic [9:0] t;
        bit         rd;
        bit         ev;
        int         elev;
        logic [7:0] ed;
        bit         ep;
        bit         ef;
        int         eerr;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_err = 0;
        m_ovf = 0;
        m_run = 0;
        m_ce  = 0;
    endtask

    task automatic model_step(input bit rx, input bit en, input logic [9:0] t, input bit rd, input bit cl);
        bit pop;
        pop = (mq.size() > 0) && rd;
        if (cl) begin
            m_err = 0;
            m_ovf = 0;
        end else begin
            if (en && (t[9] | t[8]) && m_err < 255) m_err++;
            if (en && mq.size() == 4 && !pop) m_ovf = 1;
        end
        if (pop) void'(mq.pop_front());
        if (en && mq.size() < 4) mq.push_back(t);
        if (rx) m_run = 0;
        else    m_run++;
        m_ce = !rx && (m_run >= HALF) && (((m_run - HALF) % DIV) == 0);
    endtask

    task automatic check_model();
        chk("RX_CE", rx_ce, m_ce);
        chk("VALID", bus.VALID, (mq.size() > 0));
        chk("LEVEL", level, mq.size());
        chk("OVF", ovf, m_ovf);
        chk("ERR_CNT", errcnt, m_err);
        if (mq.size() > 0) chk("HEAD", {bus.FERR, bus.PERR, bus.DATA}, mq[0]);
    endtask

    task automatic cycle(input bit rx, input bit en, input logic [9:0] t, input bit rd, input bit cl);
        rxct           = rx;
        bus.RX_DATA_EN = en;
        bus.RX_DATA_T  = t;
        bus.READY      = rd;
        clr            = cl;
        @(posedge CLK);
        model_step(rx, en, t, rd, cl);
        #1;
        check_model();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_RX_CE"}, rx_ce, 0);
        chk({tag, "_VALID"}, bus.VALID, 0);
        chk({tag, "_LEVEL"}, level, 0);
        chk({tag, "_DATA"}, bus.DATA, 0);
        chk({tag, "_PERR"}, bus.PERR, 0);
        chk({tag, "_FERR"}, bus.FERR, 0);
        chk({tag, "_OVF"}, ovf, 0);
        chk({tag, "_ERR_CNT"}, errcnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 10'h055, 1'b0, 1'b1, 1, 8'h55, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b1, 10'h1AA, 1'b0, 1'b1, 2, 8'h55, 1'b0, 1'b0, 1};
        tbl[2] = '{1'b1, 10'h2F0, 1'b0, 1'b1, 3, 8'h55, 1'b0, 1'b0, 2};
        tbl[3] = '{1'b0, 10'h000, 1'b1, 1'b1, 2, 8'hAA, 1'b1, 1'b0, 2};
        tbl[4] = '{1'b0, 10'h000, 1'b1, 1'b1, 1, 8'hF0, 1'b0, 1'b1, 2};
        tbl[5] = '{1'b0, 10'h000, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 2};

        bus.RX_DATA_EN = 1'b0;
        bus.RX_DATA_T  = '0;
        bus.READY      = 1'b0;
        model_reset();
        #12;
        chk_reset_values("RST0");
        #10;
        RST = 1'b0;

        // Bit timer: strobes after edges 4, 12, 20 of a run
        repeat (3) cycle(1, 0, '0, 0, 0);
        for (int k = 1; k <= 22; k++) begin
            cycle(0, 0, '0, 0, 0);
            chk("CE_RUN", rx_ce, (k == 4 || k == 12 || k == 20));
        end
        repeat (2) cycle(1, 0, '0, 0, 0);
        for (int k = 1; k <= 14; k++) cycle(0, 0, '0, 0, 0);
        for (int k = 15; k <= 17; k++) begin
            cycle(1, 0, '0, 0, 0);
            chk("CE_REARM", rx_ce, 0);
        end
        for (int j = 1; j <= 5; j++) begin
            cycle(0, 0, '0, 0, 0);
            chk("CE_RESTART", rx_ce, (j == 4));
        end

        // FIFO order from the vector table
        for (int i = 0; i < 6; i++) begin
            cycle(1, tbl[i].en, tbl[i].t, tbl[i].rd, 0);
            chk("TBL_VALID", bus.VALID, tbl[i].ev);
            chk("TBL_LEVEL", level, tbl[i].elev);
            chk("TBL_ERR_CNT", errcnt, tbl[i].eerr);
            if (tbl[i].ev) begin
                chk("TBL_DATA", bus.DATA, tbl[i].ed);
                chk("TBL_PERR", bus.PERR, tbl[i].ep);
                chk("TBL_FERR", bus.FERR, tbl[i].ef);
            end
        end

        // Overflow, clear, then push+pop while full
        for (int i = 0; i < 5; i++) cycle(1, 1, 10'(10'h011 + i), 0, 0);
        chk("OVF_LEVEL", level, 4);
        chk("OVF_SET", ovf, 1);
        chk("OVF_HEAD", bus.DATA, 8'h11);
        cycle(1, 0, '0, 0, 1);
        chk("OVF_CLR", ovf, 0);
        cycle(1, 1, 10'h016, 1, 0);
        chk("FULL_PP_LEVEL", level, 4);
        chk("FULL_PP_OVF", ovf, 0);
        chk("FULL_PP_HEAD", bus.DATA, 8'h12);
        repeat (4) cycle(1, 0, '0, 1, 0);
        chk("DRAIN_VALID", bus.VALID, 0);

        // Push while empty with READY high: no bypass
        cycle(1, 1, 10'h033, 1, 0);
        chk("EMPTY_VALID", bus.VALID, 1);
        chk("EMPTY_LEVEL", level, 1);
        cycle(1, 0, '0, 1, 0);
        chk("EMPTY_POPPED", bus.VALID, 0);

        // Error counter saturation, then clear alongside an error frame
        for (int i = 0; i < 300; i++) cycle(1, 1, 10'(10'h200 + (i % 256)), 1, 0);
        chk("SAT_ERR_CNT", errcnt, 255);
        cycle(1, 1, 10'h2AB, 0, 1);
        chk("CLR_ERR_CNT", errcnt, 0);
        chk("CLR_OVF", ovf, 0);
        chk("CLR_STORED", level, 2);

        // Build LEVEL=2, OVF=1 with the timer running, then reset mid-cycle
        cycle(0, 1, 10'h001, 0, 0);
        cycle(0, 1, 10'h002, 0, 0);
        cycle(0, 1, 10'h003, 0, 0);
        cycle(0, 0, '0, 1, 0);
        cycle(0, 0, '0, 1, 0);
        chk("PRE_RST_LEVEL", level, 2);
        chk("PRE_RST_OVF", ovf, 1);
        #2;
        RST = 1'b1;
        #1;
        chk_reset_values("ARST");
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("ARST_HOLD_CE", rx_ce, 0);
        chk("ARST_HOLD_LEVEL", level, 0);
        #3;
        RST = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            cycle(0, 0, '0, 0, 0);
            chk("CE_AFTER_RST", rx_ce, (j == 4));
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(15) == 0), ($urandom_range(2) == 0), 10'($urandom),
                  1'($urandom_range(1)), ($urandom_range(31) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
